// File: rtl/rvx_pkg.sv
// Shared types for the RVX ALU: operation codes, control states and the
// classifier that routes an op to the iterative multiply/divide datapath.
package rvx_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_MUL  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_DIVU = 4'b0110,
        OP_REMU = 4'b0111,
        OP_ANDN = 4'b1000,
        OP_ORN  = 4'b1001,
        OP_XNOR = 4'b1010,
        OP_ROL  = 4'b1011,
        OP_ROR  = 4'b1100,
        OP_MIN  = 4'b1101,
        OP_MAX  = 4'b1110,
        OP_ABS  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    function automatic logic is_iterative(alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/rvx_muldiv_iter.sv
// Iterative multiply / unsigned divide: one result bit per cycle for exactly
// XLEN cycles, regardless of operand values.
module rvx_muldiv_iter
    import rvx_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic            active_q, active_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    alu_op_e         mode_q, mode_d;
    // acc: product accumulator (MUL) or partial remainder (DIV)
    // x:   shifting multiplicand (MUL) or dividend/quotient (DIV)
    // y:   shifting multiplier (MUL) or divisor (DIV)
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] x_q, x_d;
    logic [XLEN-1:0] y_q, y_d;

    logic [XLEN-1:0] mul_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic            div_ok;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    always_comb begin
        mul_sum   = acc_q + (y_q[0] ? x_q : '0);
        // Remainder stays below the divisor, so XLEN+1 bits hold the trial
        // difference; with a zero divisor every trial succeeds, giving an
        // all-ones quotient and a remainder equal to the dividend.
        rem_shift = {acc_q, x_q[XLEN-1]};
        trial     = rem_shift - {1'b0, y_q};
        div_ok    = ~trial[XLEN];
        rem_next  = div_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_next  = {x_q[XLEN-2:0], div_ok};
    end

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = SHW'(XLEN - 1);
            mode_d   = op;
            acc_d    = '0;
            x_d      = a;
            y_d      = b;
        end else if (active_q) begin
            if (mode_q == OP_MUL) begin
                acc_d = mul_sum;
                x_d   = x_q << 1;
                y_d   = y_q >> 1;
            end else begin
                acc_d = rem_next;
                x_d   = quo_next;
            end
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= OP_ADD;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    // Final-step value, presented during the last active cycle so the
    // caller can register it on the same edge the iteration completes.
    always_comb begin
        done = active_q && (cnt_q == '0);
        case (mode_q)
            OP_MUL:  result = mul_sum;
            OP_REMU: result = rem_next;
            default: result = quo_next;
        endcase
    end

endmodule

// File: rtl/rvx_alu_unit.sv
// RVX ALU with valid/ready handshake: single-cycle ops computed inline,
// MUL/DIVU/REMU delegated to the iterative sub-unit.
//   state | meaning
//   IDLE  | no request outstanding, ready to accept
//   BUSY  | iterative op in progress (XLEN cycles)
//   DONE  | response held in result/zero with out_valid high
module rvx_alu_unit
    import rvx_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;

    alu_op_e         op_e;
    logic            accept;
    logic            iter_start;
    logic            iter_done;
    logic [XLEN-1:0] iter_result;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  sh;
    logic [SHW-1:0]  sh_inv;
    logic            lt_s;

    assign op_e       = alu_op_e'(op);
    assign in_ready   = reset_n &&
                        ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign accept     = in_valid && in_ready;
    assign iter_start = accept && is_iterative(op_e);

    always_comb begin
        sh     = b[SHW-1:0];
        sh_inv = SHW'(0) - sh;
        lt_s   = $signed(a) < $signed(b);
        alu_res = '0;
        case (op_e)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_ANDN: alu_res = a & ~b;
            OP_ORN:  alu_res = a | ~b;
            OP_XNOR: alu_res = ~(a ^ b);
            // Zero amount bypasses the complementary shift entirely.
            OP_ROL:  alu_res = (sh == '0) ? a : ((a << sh) | (a >> sh_inv));
            OP_ROR:  alu_res = (sh == '0) ? a : ((a >> sh) | (a << sh_inv));
            OP_MIN:  alu_res = lt_s ? a : b;
            OP_MAX:  alu_res = lt_s ? b : a;
            OP_ABS:  alu_res = a[XLEN-1] ? (XLEN'(0) - a) : a;
            OP_MUL, OP_DIVU, OP_REMU: alu_res = '0;
        endcase
    end

    rvx_muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (iter_start),
        .op      (op_e),
        .a       (a),
        .b       (b),
        .done    (iter_done),
        .result  (iter_result)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_BUSY: begin
                if (iter_done) begin
                    state_d     = ST_DONE;
                    result_d    = iter_result;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready && !accept) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (accept) begin
            if (is_iterative(op_e)) begin
                state_d     = ST_BUSY;
                out_valid_d = 1'b0;
            end else begin
                state_d     = ST_DONE;
                result_d    = alu_res;
                out_valid_d = 1'b1;
            end
        end
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rvx_alu_unit.sv
// Directed and randomized checks of rvx_alu_unit against a plain-arithmetic
// reference model, including handshake hold, back-to-back and mid-op reset.
module tb_rvx_alu_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    rvx_alu_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_i),
        .a         (a_i),
        .b         (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        int s;
        s = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd7:  return (b == 0) ? a : a % b;
            4'd8:  return a & ~b;
            4'd9:  return a | ~b;
            4'd10: return ~(a ^ b);
            4'd11: return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            4'd12: return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            4'd13: return ($signed(a) < $signed(b)) ? a : b;
            4'd14: return ($signed(a) < $signed(b)) ? b : a;
            default: return ($signed(a) < 0) ? (32'd0 - a) : a;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op);
        return (op == 4'd4 || op == 4'd6 || op == 4'd7) ? 33 : 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one request from IDLE, then measure latency and check the response.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat);
        int cycles;
        @(negedge clk);
        in_valid  = 1'b1;
        op_i      = op;
        a_i       = a;
        b_i       = b;
        out_ready = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_i     = 4'($urandom_range(0, 15));
        a_i      = $urandom;
        b_i      = $urandom;
        cycles   = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 2 && exp_lat > 1) begin
                check({tag, "_busy_mid"}, {busy, in_ready, out_valid}, 3'b100);
            end
        end while (!out_valid && cycles < 200);
        check({tag, "_latency"}, cycles, exp_lat);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, zero, (exp_res == 0));
    endtask

    initial begin
        logic [31:0] x[8];
        logic [31:0] y[8];
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_i      = 4'd0;
        a_i       = '0;
        b_i       = '0;
        #3;
        check("reset_outputs", {out_valid, zero, busy, in_ready}, 4'b0000);
        check("reset_result", result, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("rol0",   4'd11, 32'h8000_0001, 32'd0,  32'h8000_0001, 1);
        run_op("rol4",   4'd11, 32'h8000_0001, 32'd4,  32'h0000_0018, 1);
        run_op("ror1",   4'd12, 32'h0000_0001, 32'd1,  32'h8000_0000, 1);
        run_op("ror32",  4'd12, 32'h0000_0001, 32'd32, 32'h0000_0001, 1);
        run_op("mul7x6", 4'd4,  32'd7,  32'd6,  32'd42, 33);
        run_op("mulmax", 4'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run_op("divu",   4'd6,  32'd100, 32'd7, 32'd14, 33);
        run_op("remu",   4'd7,  32'd100, 32'd7, 32'd2,  33);
        run_op("divu0",  4'd6,  32'd100, 32'd0, 32'hFFFF_FFFF, 33);
        run_op("remu0",  4'd7,  32'd100, 32'd0, 32'd100, 33);
        run_op("absmin", 4'd15, 32'h8000_0000, 32'd0, 32'h8000_0000, 1);
        run_op("sub0",   4'd1,  32'd5, 32'd5, 32'd0, 1);
        run_op("slt",    4'd5,  32'h8000_0000, 32'd1, 32'd1, 1);
        run_op("min",    4'd13, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1);
        run_op("max",    4'd14, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);

        // Hold the response, then stream eight ADDs back-to-back.
        for (int i = 0; i < 8; i++) begin
            x[i] = $urandom;
            y[i] = $urandom;
        end
        @(negedge clk);
        in_valid  = 1'b1;
        op_i      = 4'd0;
        a_i       = 32'd10;
        b_i       = 32'd20;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        a_i = x[0];
        b_i = y[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, 30);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            check("b2b_valid", out_valid, 1);
            check("b2b_result", result, model(4'd0, x[j-1], y[j-1]));
            if (j < 8) begin
                a_i = x[j];
                b_i = y[j];
            end else begin
                in_valid = 1'b0;
            end
        end

        // Reset in the middle of a MUL: no response may follow.
        @(negedge clk);
        in_valid = 1'b1;
        op_i     = 4'd4;
        a_i      = 32'd7;
        b_i      = 32'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_flags", {out_valid, busy, in_ready}, 3'b000);
        check("abort_result", result, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_response", seen, 0);
        run_op("post_reset_add", 4'd0, 32'd2, 32'd3, 32'd5, 1);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb),
                   model_lat(rop));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rvx_alu_unit.md
RVX_ALU_UNIT -- requirements
Module: rvx_alu_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; legal values 8..64, power of two.
REQ-002 Parameter: SHW, $clog2(XLEN), rotate-amount width; derived from XLEN, never overridden.
REQ-003 Port: clk  input  1  single clock, rising-edge.
REQ-004 Port: reset_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  request valid.
REQ-006 Port: in_ready  output  1  unit can accept a request.
REQ-007 Port: op  input  4  operation code (REQ-011).
REQ-008 Port: a, b  input  XLEN  source operands.
REQ-009 Port: out_valid, out_ready  output/input  1  response handshake.
REQ-010 Port: result  output  XLEN  registered result; zero  output  1  result==0; busy  output  1  state!=IDLE.

Function
REQ-011 Op codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT, 1000 ANDN, 1001 ORN, 1010 XNOR, 1011 ROL, 1100 ROR, 1101 MIN, 1110 MAX, 1111 ABS (single-cycle); 0100 MUL, 0110 DIVU, 0111 REMU (iterative).
REQ-012 States: IDLE, BUSY, DONE; acceptance = in_valid & in_ready.
REQ-013 in_ready = (state==IDLE) | (state==DONE & out_ready); request fields sampled only on acceptance.
REQ-014 Single-cycle op accepted in cycle k: DONE and out_valid=1 in cycle k+1.
REQ-015 Iterative op accepted in cycle k: BUSY for exactly XLEN cycles; out_valid=1 in cycle k+XLEN+1, independent of operand values.
REQ-016 DONE: result and zero held stable while out_valid & !out_ready; on out_ready, go to IDLE, or capture the new request if in_valid is high (back-to-back, one single-cycle op per cycle).
REQ-017 SLT signed and overflow-correct; MIN/MAX signed compare; ABS of the most-negative value returns that value unchanged.
REQ-018 ROL/ROR rotate by b[SHW-1:0]; an amount of 0 returns a exactly, with no shift-by-XLEN term.
REQ-019 MUL returns the low XLEN bits of the unsigned product, computed by shift-add, one bit per BUSY cycle.
REQ-020 DIVU/REMU unsigned restoring division, one bit per BUSY cycle; b==0 gives DIVU all-ones and REMU = a, with the same latency.
REQ-021 An unlisted op code cannot occur (4-bit space fully decoded).
REQ-022 result, zero and out_valid are driven from flops only; no combinational path from a/b/op to result.

Reset
REQ-023 reset_n low asynchronously forces state=IDLE, out_valid=0, result=0, zero=0, busy=0 and clears the iteration counter.
REQ-024 Reset during BUSY or DONE aborts the operation with no response; the first accepted request after deassertion behaves per REQ-014/015.
REQ-025 in_ready is 0 while reset_n is low.

Structure
REQ-026 Shared package rvx_pkg holds the alu_op_e enum (REQ-011 codes), the state enum, and an is_iterative(op) function.
REQ-027 Iterative datapath in one sub-module, rvx_muldiv_iter (start, op, a, b -> done, result, XLEN-cycle counter); single-cycle ops stay inline in rvx_alu_unit.

Verification (XLEN=32)
REQ-028 ROL a=0x80000001: b=0 -> 0x80000001; b=4 -> 0x00000018. ROR a=0x00000001, b=1 -> 0x80000000; b=32 (amount 0) -> 0x00000001.
REQ-029 MUL a=7, b=6 accepted in cycle k -> out_valid first high in cycle k+33, result=42, zero=0; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
REQ-030 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; all with latency 33.
REQ-031 ABS 0x80000000 -> 0x80000000; SUB 5-5 -> 0 with zero=1; SLT 0x80000000,1 -> 1; MIN -1,1 -> 0xFFFFFFFF; MAX -1,1 -> 1.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0; then 8 back-to-back ADDs with out_ready=1 -> 8 responses in 8 consecutive cycles, in order.
REQ-033 Pull reset_n low in cycle k+10 of a MUL -> out_valid=0, busy=0 immediately, no response; a following ADD 2+3 -> 5 in the next cycle.
